bus_mux_keeper: RTL and testbench

- Parametrised successor to the datapath bus multiplexer: NUM_SRC sources of WIDTH bits drive one shared bus under per-source out-enables.
- Adds a flop-based bus keeper: last driven value is held when no source is enabled, replacing an inferred latch.
- Adds a selectable arbitration mode, multiple-driver contention detection with a sticky flag and a saturating event counter, and a registered source index for debug/trace.
- Sits between the register file/special registers (HI, LO, Z, PC, MDR, InPort, C) and all bus consumers.

---
 rtl/bus_mux_keeper.sv | 81 ++++++++
 tb/tb_bus_mux_keeper.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_keeper.sv
// Shared datapath bus multiplexer with a flop-based keeper.
// Sources are selected by per-source out-enables. Index 0 has the highest priority.
// When no source drives the bus, the last driven value is held.
// Multi-driver cycles are flagged with a sticky bit and counted in a saturating counter.
module bus_mux_keeper #(
  parameter int WIDTH         = 32,
  parameter int NUM_SRC       = 24,
  parameter int PRIORITY_MODE = 1,
  parameter int CNT_W         = 8,
  parameter int IDX_W         = $clog2(NUM_SRC)
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_sel,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_driven,
  output logic [IDX_W-1:0]         last_src,
  output logic                     contention,
  output logic [CNT_W-1:0]         contention_cnt
);

  logic [WIDTH-1:0] keeper;
  logic [WIDTH-1:0] win_data;
  logic [IDX_W-1:0] win;
  logic             any_sel;
  logic             multi_sel;

  // Priority decode: the lowest enabled index wins; note whether a second enable is present.
  always_comb begin
    win       = '0;
    win_data  = '0;
    any_sel   = 1'b0;
    multi_sel = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel[i]) begin
        if (!any_sel) begin
          any_sel  = 1'b1;
          win      = IDX_W'(i);
          win_data = src_data[i*WIDTH +: WIDTH];
        end else begin
          multi_sel = 1'b1;
        end
      end
    end
  end

  // Bus value. In non-priority mode a multi-select cycle falls back to the kept value.
  always_comb begin
    bus_driven = any_sel && ((PRIORITY_MODE != 0) || !multi_sel);
    bus_out    = bus_driven ? win_data : keeper;
  end

  // Keeper and trace index. Both follow the bus only in cycles where a source actually drives it.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      keeper   <= '0;
      last_src <= '0;
    end else if (bus_driven) begin
      keeper   <= bus_out;
      last_src <= win;
    end
  end

  // Contention tracking. A clear wins over a same-cycle event, and that event is dropped.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      contention     <= 1'b0;
      contention_cnt <= '0;
    end else if (err_clr) begin
      contention     <= 1'b0;
      contention_cnt <= '0;
    end else if (multi_sel) begin
      contention <= 1'b1;
      if (contention_cnt != {CNT_W{1'b1}})
        contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_mux_keeper.sv
// Scoreboard bench for bus_mux_keeper.
// Two instances share the same stimulus.
// dut_p1: priority mode, with a 2-bit counter so that saturation is reached.
// dut_p0: flag-only mode, with the default 8-bit counter.
module tb_bus_mux_keeper;

  localparam int W  = 32;
  localparam int NS = 24;

  logic          clock = 1'b0;
  logic          clear_n;
  logic [NS*W-1:0] src_data, next_data;
  logic [NS-1:0] src_sel;
  logic          err_clr;

  logic [W-1:0]  bus1, bus0;
  logic          drv1, drv0;
  logic [4:0]    last1, last0;
  logic          cont1, cont0;
  logic [1:0]    cnt1;
  logic [7:0]    cnt0;

  always #5 clock = ~clock;

  bus_mux_keeper #(.WIDTH(W), .NUM_SRC(NS), .PRIORITY_MODE(1), .CNT_W(2)) dut_p1 (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_sel(src_sel),
    .err_clr(err_clr), .bus_out(bus1), .bus_driven(drv1), .last_src(last1),
    .contention(cont1), .contention_cnt(cnt1));

  bus_mux_keeper #(.WIDTH(W), .NUM_SRC(NS), .PRIORITY_MODE(0), .CNT_W(8)) dut_p0 (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_sel(src_sel),
    .err_clr(err_clr), .bus_out(bus0), .bus_driven(drv0), .last_src(last0),
    .contention(cont0), .contention_cnt(cnt0));

  typedef struct {
    logic [31:0] bus1, bus0;
    logic        drv1, drv0;
    int          last1, last0;
    logic        cont1, cont0;
    int          cnt1, cnt0;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 0;

  // Reference state: what each bus consumer should observe.
  logic [31:0] m_keep1, m_keep0;
  int          m_last1, m_last0, m_cnt1, m_cnt0;
  logic        m_cont1, m_cont0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_keep1 = 0; m_keep0 = 0; m_last1 = 0; m_last0 = 0;
    m_cnt1 = 0; m_cnt0 = 0; m_cont1 = 0; m_cont0 = 0;
  endtask

  // Apply one cycle of stimulus between clock edges.
  // Then record the expected observation and advance the model across the next edge.
  task automatic step(input logic [NS-1:0] sel, input logic err, input logic rst);
    exp_t        e;
    int          n, win;
    logic [31:0] dw;
    @(posedge clock); #1;
    src_data = next_data;
    src_sel  = sel;
    err_clr  = err;
    clear_n  = !rst;
    if (rst) model_reset();
    n   = $countones(sel);
    win = 0;
    for (int i = NS - 1; i >= 0; i--) if (sel[i]) win = i;
    dw = next_data[win*W +: W];
    e.bus1 = (n > 0) ? dw : m_keep1;
    e.drv1 = (n > 0);
    e.bus0 = (n == 1) ? dw : m_keep0;
    e.drv0 = (n == 1);
    e.last1 = m_last1; e.last0 = m_last0;
    e.cont1 = m_cont1; e.cont0 = m_cont0;
    e.cnt1  = m_cnt1;  e.cnt0  = m_cnt0;
    q.push_back(e);
    if (!rst) begin
      if (e.drv1) begin m_keep1 = dw; m_last1 = win; end
      if (e.drv0) begin m_keep0 = dw; m_last0 = win; end
      if (err) begin
        m_cont1 = 0; m_cnt1 = 0; m_cont0 = 0; m_cnt0 = 0;
      end else if (n >= 2) begin
        m_cont1 = 1; m_cont0 = 1;
        if (m_cnt1 < 3)   m_cnt1++;
        if (m_cnt0 < 255) m_cnt0++;
      end
    end
  endtask

  // Monitor: compare one queued expectation per cycle, sampling mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bus_p1",  bus1,          e.bus1);
        chk("drv_p1",  32'(drv1),     32'(e.drv1));
        chk("last_p1", 32'(last1),    32'(e.last1));
        chk("cont_p1", 32'(cont1),    32'(e.cont1));
        chk("cnt_p1",  32'(cnt1),     32'(e.cnt1));
        chk("bus_p0",  bus0,          e.bus0);
        chk("drv_p0",  32'(drv0),     32'(e.drv0));
        chk("last_p0", 32'(last0),    32'(e.last0));
        chk("cont_p0", 32'(cont0),    32'(e.cont0));
        chk("cnt_p0",  32'(cnt0),     32'(e.cnt0));
      end
    end
  end

  initial begin
    logic [NS-1:0] sel;
    logic [NS-1:0] multi;
    int            kind;
    clear_n   = 1'b0;
    src_sel   = '0;
    err_clr   = 1'b0;
    src_data  = '0;
    next_data = '0;
    model_reset();

    step('0, 0, 1);
    step('0, 0, 0);

    next_data[5*W +: W] = 32'hDEADBEEF;
    step(NS'(1) << 5, 0, 0);
    step('0, 0, 0);
    step('0, 0, 0);

    next_data[7*W +: W] = 32'hA5A5A5A5;
    step(NS'(1) << 7, 0, 0);
    next_data[3*W +: W]  = 32'h11;
    next_data[20*W +: W] = 32'h22;
    multi = (NS'(1) << 3) | (NS'(1) << 20);
    step(multi, 0, 0);
    step('0, 0, 0);

    step('0, 1, 0);
    for (int i = 0; i < 5; i++) step(multi, 0, 0);
    step(multi, 1, 0);
    step('0, 0, 0);

    next_data[23*W +: W] = 32'h1234;
    step(NS'(1) << 23, 0, 0);
    step(NS'(1) << 23, 0, 1);
    step('0, 0, 0);
    step('0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NS; s++) next_data[s*W +: W] = $urandom;
      kind = $urandom_range(0, 9);
      if (kind < 3)      sel = '0;
      else if (kind < 7) sel = NS'(1) << $urandom_range(0, NS - 1);
      else               sel = NS'($urandom) | (NS'(1) << $urandom_range(0, NS - 1));
      step(sel, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end

    step('0, 0, 0);
    stim_done = 1;
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clock);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
